// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default parameter values, status flag struct, depth->address-width helper.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_THRESH = 12;
  localparam int DEF_AE_THRESH = 2;
  localparam bit DEF_FWFT      = 1'b0;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Number of address bits needed to index 'depth' entries.
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the owner decides when writes are legal.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o read port.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [clog2_depth(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic [clog2_depth(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]             rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags, flush and optional FWFT read.
// Latency: FWFT=0 rdata valid 1 cycle after an accepted pop; FWFT=1 head word visible 1 cycle after write.
// Backpressure: writes rejected when full (unless a pop is accepted in the same cycle), reads rejected
//   when empty; each rejection raises a 1-cycle overflow/underflow pulse the following cycle.
// Ports: clk, rst (async active-low), clear; wr_en/wdata in; rd_en in, rdata/rvalid out;
//   full/empty/almost_full/almost_empty/count status; overflow/underflow error pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter bit FWFT      = DEF_FWFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = clog2_depth(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH-1");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 2) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-2");
  end

  // Pointers carry an extra wrap bit above the address bits.
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_status_t      stat_q, stat_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_ok, rd_ok;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
  assign rd_ok  = rd_en & ~stat_q.empty;
  assign wr_ok  = wr_en & (~stat_q.full | rd_ok);
  assign mem_we = wr_ok & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + CW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
      ovf_d   = wr_en & ~wr_ok;
      unf_d   = rd_en & ~rd_ok;
    end
    // Flags come from the next count so they move on the same edge as the pointers.
    stat_d.full         = (count_d == CW'(DEPTH));
    stat_d.empty        = (count_d == '0);
    stat_d.almost_full  = (count_d >= CW'(AF_THRESH));
    stat_d.almost_empty = (count_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stat_q   <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stat_q   <= stat_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Head of queue is presented directly from the array.
    assign rdata  = mem_rdata;
    assign rvalid = ~stat_q.empty;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (clear) begin
        rvalid_q <= 1'b0;
      end else if (rd_ok) begin
        rdata_q  <= mem_rdata;
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign full         = stat_q.full;
  assign empty        = stat_q.empty;
  assign almost_full  = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one registered-read and one FWFT instance share stimulus and are compared
// against a queue-based reference of the FIFO's accept rules.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;

  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic          ovf0, ovf1, unf0, unf1;
  logic [3:0]    count0, count1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .count(count0)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .count(count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd0;
  logic          exp_rv0;
  logic          exp_ovf;
  logic          exp_unf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd0 = '0;
    exp_rv0 = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // Applies one clock edge's worth of FIFO rules to the queue.
  task automatic model_edge(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
    bit rd_ok, wr_ok;
    if (c) begin
      q.delete();
      exp_rv0 = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      rd_ok   = r && (q.size() > 0);
      wr_ok   = w && ((q.size() < DEPTH) || rd_ok);
      exp_ovf = w && !wr_ok;
      exp_unf = r && !rd_ok;
      if (rd_ok) begin
        exp_rd0 = q.pop_front();
        exp_rv0 = 1'b1;
      end else begin
        exp_rv0 = 1'b0;
      end
      if (wr_ok) q.push_back(wd);
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ".r.count"},  32'(count0), 32'(n));
    chk({ph, ".r.full"},   32'(full0),  32'(n == DEPTH));
    chk({ph, ".r.empty"},  32'(empty0), 32'(n == 0));
    chk({ph, ".r.afull"},  32'(af0),    32'(n >= AF));
    chk({ph, ".r.aempty"}, 32'(ae0),    32'(n <= AE));
    chk({ph, ".r.ovf"},    32'(ovf0),   32'(exp_ovf));
    chk({ph, ".r.unf"},    32'(unf0),   32'(exp_unf));
    chk({ph, ".r.rvalid"}, 32'(rvalid0), 32'(exp_rv0));
    chk({ph, ".r.rdata"},  32'(rdata0), 32'(exp_rd0));
    chk({ph, ".f.count"},  32'(count1), 32'(n));
    chk({ph, ".f.full"},   32'(full1),  32'(n == DEPTH));
    chk({ph, ".f.empty"},  32'(empty1), 32'(n == 0));
    chk({ph, ".f.afull"},  32'(af1),    32'(n >= AF));
    chk({ph, ".f.aempty"}, 32'(ae1),    32'(n <= AE));
    chk({ph, ".f.ovf"},    32'(ovf1),   32'(exp_ovf));
    chk({ph, ".f.unf"},    32'(unf1),   32'(exp_unf));
    chk({ph, ".f.rvalid"}, 32'(rvalid1), 32'(n > 0));
    if (n > 0) chk({ph, ".f.rdata"}, 32'(rdata1), 32'(q[0]));
  endtask

  // Called just after a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic step(input string ph, input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
    wr_en = w;
    wdata = wd;
    rd_en = r;
    clear = c;
    @(posedge clk);
    model_edge(w, wd, r, c);
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    logic [DW-1:0] v;
    rst   = 1'b0;
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x01..0x08, then one write too many.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    step("ovf", 1'b1, 8'h99, 1'b0, 1'b0);
    chk("t1.ovf_pulse", 32'(ovf0), 32'd1);
    step("ovf_drop", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain all, then one read too many.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2.last_word", 32'(rdata0), 32'h08);
    step("unf", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2.unf_pulse", 32'(unf0), 32'd1);
    step("unf_drop", 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push/pop on a full FIFO.
    for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, DW'(i), 1'b0, 1'b0);
    step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t3.no_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3.aa_last", 32'(rdata0), 32'hAA);

    // Push and pop together on an empty FIFO: write taken, read rejected.
    step("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0);
    step("flush0", 1'b0, 8'h00, 1'b0, 1'b1);

    // Streaming across two pointer wraps at constant occupancy.
    for (int i = 0; i < 3; i++) step("prefill", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, DW'($urandom_range(255)), 1'b1, 1'b0);
      chk("t4.count3", 32'(count0), 32'd3);
    end
    for (int i = 0; i < 3; i++) step("stream_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Single word into empty FIFO: visible on FWFT output with no pop.
    step("fwft_w", 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t5.fwft_head", 32'(rdata1), 32'h5A);
    step("fwft_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush, then asynchronous reset in the middle of a write.
    for (int i = 0; i < 5; i++) step("pre_clr", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    step("clear", 1'b1, 8'hEE, 1'b1, 1'b1);
    step("post_clr", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, DW'(8'hD0 + i), 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    wr_en = 1'b1;
    wdata = 8'h77;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    check_all("rst_hold");

    // Random traffic, occasional flush.
    for (int i = 0; i < 400; i++) begin
      v = DW'($urandom_range(255));
      step("rand", 1'($urandom_range(1)), v, 1'($urandom_range(1)), 1'($urandom_range(31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
